nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle wide adder that processes WIDTH-bit operands one 4-bit nibble per clock. It uses the same 4-bit add slice as the team's ripple adder, with a registered carry chained between nibbles. The block sits upstream of consumers that need wide sums. Each nibble sum and carry-out is consumed internally, and the completed word is presented on a valid/ready output. It trades latency for a single 4-bit slice of logic regardless of operand width.

## Interface
- `WIDTH`, default 16: operand/sum width. Must be a multiple of 4 and ≥ 8. N = WIDTH/4 nibbles.
- `clk`  input  1: sole clock; rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `in_valid`  input  1: operands a/b valid.
- `in_ready`  output  1: block can accept operands; high only in IDLE.
- `a`  input  WIDTH: operand A, sampled on the input handshake.
- `b`  input  WIDTH: operand B, sampled on the input handshake.
- `out_valid`  output  1: sum/cout valid; high only in DONE.
- `out_ready`  input  1: downstream accepts result.
- `sum`  output  WIDTH: registered result word.
- `cout`  output  1: registered carry out of the top nibble.
- `sub`  input  1: present only with NIBBLE_SUB_EN. It is sampled with a/b, and 1 selects a − b.

## Operation
- Input handshake: in_valid && in_ready at a rising edge. Output handshake: out_valid && out_ready at a rising edge.
- FSM states: IDLE, RUN, DONE. Encoding is free.
- IDLE
  - in_ready = 1.
  - On the input handshake: latch a and b into operand registers, clear nibble index to 0, load the carry register (0, or 1 for a subtract), clear sum, then go to RUN.
- RUN, one nibble per edge at index i:
  - t = a[4i+3:4i] + b'[4i+3:4i] + carry, a 5-bit result.
  - sum[4i+3:4i] ← t[3:0] and carry ← t[4].
  - b' = b, or ~b when subtracting.
  - On i = N−1: write the nibble, set cout ← t[4], go to DONE. Otherwise i ← i+1.
- DONE
  - out_valid = 1; sum and cout are held stable.
  - On the output handshake, go to IDLE.
- in_valid is ignored outside IDLE.
- a/b changes after the handshake have no effect.
- Arithmetic is modulo 2^WIDTH; cout is the true carry out of bit WIDTH−1.
- sum may show partial nibbles during RUN. It is only valid when out_valid = 1.
- Reset, asynchronous and possible at any time including mid-RUN:
  - state = IDLE, out_valid = 0, in_ready = 1, sum = 0, cout = 0, carry = 0, index = 0.
  - An operation in progress is discarded with no output.

## Timing
- Input accepted at edge E0. Nibbles 0..N−1 are computed at edges E1..EN, and out_valid rises after EN.
- Latency is N cycles: 4 for WIDTH = 16, 2 for WIDTH = 8.
- out_valid falls at the output handshake edge. in_ready rises in the same cycle, and the next input can be accepted at the following edge.
- Minimum initiation interval is N+2 cycles with out_ready held high.
- Backpressure: DONE may last any number of cycles. in_ready stays 0 throughout.
- in_ready and out_valid are decoded from the state register only, with no combinational path from any input.

## Configuration
- `NIBBLE_SUB_EN` defined:
  - `sub` port exists. sub = 1 gives the two's-complement result a + ~b + 1: the carry register is loaded with 1 and each b nibble is inverted.
  - cout = 1 means no borrow (a ≥ b unsigned).
  - sub = 0 behaves exactly as plain addition.
- `NIBBLE_SUB_EN` undefined: no `sub` port; addition only, with initial carry 0.

## Test plan
- WIDTH = 16: a = 0x1234, b = 0x4321 → sum = 0x5555, cout = 0, out_valid exactly 4 edges after acceptance.
- WIDTH = 16: a = 0xFFFF, b = 0x0001 → sum = 0x0000, cout = 1, carry propagating through all 4 nibbles. Then a = 0x8000, b = 0x8000 → sum = 0x0000, cout = 1.
- Backpressure: 0x00F0 + 0x0010, out_ready low for 3 cycles after out_valid → sum = 0x0100 held, in_ready = 0, an in_valid pulse with 0xAAAA is ignored. out_ready high → handshake, IDLE next cycle.
- Reset mid-RUN: assert rst_n = 0 after edge E2 of 0xFFFF + 0xFFFF → immediately out_valid = 0, sum = 0, cout = 0, in_ready = 1. After release, 0x0001 + 0x0001 → sum = 0x0002, cout = 0, proving no stale carry.
- WIDTH = 8 instance: 0xF7 + 0x19 → sum = 0x10, cout = 1, latency 2.
- NIBBLE_SUB_EN, WIDTH = 16:
  - 0x0007 − 0x0005 → sum 0x0002, cout = 1.
  - 0x0005 − 0x0007 → sum 0xFFFE, cout = 0.
  - 0x1234 − 0x1234 → sum 0x0000, cout = 1.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - multi-cycle wide adder, one 4-bit nibble per clock
//
// Purpose:
//   Adds two WIDTH-bit operands through a single 4-bit add slice. The carry
//   between nibbles is held in a register. Operands are taken on a valid/ready
//   input handshake. The finished sum and carry-out are offered on a valid/ready
//   output handshake.
//
// Configuration:
//   NIBBLE_SUB_EN - when defined, adds the 'sub' input. With sub = 1 the block
//                   computes a - b as a + ~b + 1, and cout = 1 means no borrow.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands a/b (and sub) valid
//   in_ready   out  block idle and able to accept operands
//   a, b       in   WIDTH-bit operands, sampled on the input handshake
//   sub        in   (NIBBLE_SUB_EN only) 1 selects a - b
//   out_valid  out  sum/cout valid
//   out_ready  in   downstream accepts the result
//   sum        out  WIDTH-bit registered result
//   cout       out  registered carry out of bit WIDTH-1
//
// WIDTH must be a multiple of 4 and at least 8.

module nibble_serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef NIBBLE_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int N  = WIDTH / 4;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;     // already inverted when subtracting
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;

  logic [3:0]       a_nib;
  logic [3:0]       b_nib;
  logic [4:0]       t;

  // The one shared 4-bit slice, fed by the nibble selected by idx.
  always_comb begin
    a_nib = a_q[{idx, 2'b00} +: 4];
    b_nib = b_q[{idx, 2'b00} +: 4];
    t     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0000, carry};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q   <= a;
`ifdef NIBBLE_SUB_EN
            // Two's-complement subtract: invert b once here, seed carry with 1.
            b_q   <= sub ? ~b : b;
            carry <= sub;
`else
            b_q   <= b;
            carry <= 1'b0;
`endif
            idx   <= '0;
            sum_q <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_q[{idx, 2'b00} +: 4] <= t[3:0];
          carry                    <= t[4];
          if (idx == LAST) begin
            cout_q <= t[4];
            state  <= DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake flags come from the state register alone.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - directed self-checking bench for nibble_serial_adder

module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        in_valid, in_ready, out_valid, out_ready, cout;
  logic [15:0] a, b, sum;
  logic        sub;

  logic        in_valid8, in_ready8, out_valid8, out_ready8, cout8;
  logic [7:0]  a8, b8, sum8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
`ifdef NIBBLE_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
  );

  nibble_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid8), .in_ready(in_ready8), .a(a8), .b(b8),
`ifdef NIBBLE_SUB_EN
    .sub(1'b0),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8), .sum(sum8), .cout(cout8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Launch one 16-bit operation, then check latency, sum and cout once out_valid is up.
  task automatic start16(input logic [15:0] av, input logic [15:0] bv, input logic sv,
                         input logic [15:0] exp_sum, input logic exp_cout, input string tag);
    int lat;
    in_valid = 1'b1; a = av; b = bv; sub = sv;
    @(negedge clk);                       // E0 has accepted the operands
    in_valid = 1'b0; a = ~av; b = ~bv;    // later changes must not matter
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, " latency"}, lat, 4);
    chk({tag, " sum"}, {16'h0, sum}, {16'h0, exp_sum});
    chk({tag, " cout"}, {31'h0, cout}, {31'h0, exp_cout});
  endtask

  // Complete the output handshake and confirm the block is idle again.
  task automatic finish16(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, " out_valid after handshake"}, {31'h0, out_valid}, 32'h0);
    chk({tag, " in_ready after handshake"}, {31'h0, in_ready}, 32'h1);
  endtask

  initial begin
    int lat;
    rst_n = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sub = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0;

    // Reset state
    @(negedge clk);
    chk("reset out_valid", {31'h0, out_valid}, 32'h0);
    chk("reset in_ready", {31'h0, in_ready}, 32'h1);
    chk("reset sum", {16'h0, sum}, 32'h0);
    chk("reset cout", {31'h0, cout}, 32'h0);
    chk("reset in_ready8", {31'h0, in_ready8}, 32'h1);
    rst_n = 1'b1;
    @(negedge clk);

    // Plain add, no carries
    start16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "add1234");
    finish16("add1234");

    // Carry rippling through every nibble
    start16(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, "addFFFF");
    finish16("addFFFF");

    // Carry only out of the top bit
    start16(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, "add8000");
    finish16("add8000");

    // Backpressure: result held, in_ready low, stray input ignored
    start16(16'h00F0, 16'h0010, 1'b0, 16'h0100, 1'b0, "bp");
    for (int i = 0; i < 3; i++) begin
      in_valid = (i == 1); a = 16'hAAAA; b = 16'hAAAA;
      @(negedge clk);
      chk("bp sum held", {16'h0, sum}, 32'h0100);
      chk("bp out_valid held", {31'h0, out_valid}, 32'h1);
      chk("bp in_ready low", {31'h0, in_ready}, 32'h0);
    end
    in_valid = 1'b0;
    finish16("bp");
    @(negedge clk);
    chk("bp stays idle", {31'h0, in_ready}, 32'h1);

    // Reset in the middle of RUN
    in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);                       // E1
    @(posedge clk);                       // E2
    #1 rst_n = 1'b0;
    #1;
    chk("midrun out_valid", {31'h0, out_valid}, 32'h0);
    chk("midrun sum", {16'h0, sum}, 32'h0);
    chk("midrun cout", {31'h0, cout}, 32'h0);
    chk("midrun in_ready", {31'h0, in_ready}, 32'h1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start16(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, "post_reset");
    finish16("post_reset");

    // 8-bit instance: two nibbles, latency 2
    in_valid8 = 1'b1; a8 = 8'hF7; b8 = 8'h19;
    @(negedge clk);
    in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    lat = 0;
    while (!out_valid8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("w8 latency", lat, 2);
    chk("w8 sum", {24'h0, sum8}, 32'h10);
    chk("w8 cout", {31'h0, cout8}, 32'h1);
    out_ready8 = 1'b1;
    @(negedge clk);
    out_ready8 = 1'b0;
    chk("w8 in_ready after handshake", {31'h0, in_ready8}, 32'h1);

`ifdef NIBBLE_SUB_EN
    start16(16'h0007, 16'h0005, 1'b1, 16'h0002, 1'b1, "sub7m5");
    finish16("sub7m5");
    start16(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, "sub5m7");
    finish16("sub5m7");
    start16(16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, "sub_eq");
    finish16("sub_eq");
    start16(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, "sub0_add");
    finish16("sub0_add");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
